ctrl_sequencer: RTL

- Hardwired control unit for the phase-1 datapath (`bus`).
- Generates the per-step register in/out strobes, memory strobes and ALU select that the datapath consumes.
- Steps the datapath through fetch (T0-T2) and execute (T3-T6) for ALU-class instructions, replacing manually sequenced control.
- Sits beside `bus`; takes the IR contents and a memory-ready flag back.

---
 rtl/ctrl_pkg.sv | 121 ++++++++++++
 rtl/reg_sel_decoder.sv | 20 ++
 rtl/ctrl_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared opcode constants, ALU-select bit positions, sequencer
//             state encoding and opcode-classification helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Opcode values as found in ir[31:27]
  localparam logic [4:0] c_op_add  = 5'd0;
  localparam logic [4:0] c_op_sub  = 5'd1;
  localparam logic [4:0] c_op_and  = 5'd2;
  localparam logic [4:0] c_op_or   = 5'd3;
  localparam logic [4:0] c_op_shr  = 5'd4;
  localparam logic [4:0] c_op_shl  = 5'd5;
  localparam logic [4:0] c_op_ror  = 5'd6;
  localparam logic [4:0] c_op_rol  = 5'd7;
  localparam logic [4:0] c_op_not  = 5'd8;
  localparam logic [4:0] c_op_neg  = 5'd9;
  localparam logic [4:0] c_op_mul  = 5'd10;
  localparam logic [4:0] c_op_div  = 5'd11;
  localparam logic [4:0] c_op_nop  = 5'd12;
  localparam logic [4:0] c_op_halt = 5'd13;

  // Bit positions inside the one-hot ALUControl word
  localparam int c_alu_add = 0;
  localparam int c_alu_sub = 1;
  localparam int c_alu_and = 2;
  localparam int c_alu_or  = 3;
  localparam int c_alu_shr = 4;
  localparam int c_alu_shl = 5;
  localparam int c_alu_ror = 6;
  localparam int c_alu_rol = 7;
  localparam int c_alu_mul = 8;
  localparam int c_alu_div = 9;
  localparam int c_alu_neg = 10;
  localparam int c_alu_not = 11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3    = 3'd0,
    CLS_UNARY   = 3'd1,
    CLS_NOP     = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_e;

  // Single-bit strobes plus ALU select; register selects are carried separately
  typedef struct packed {
    logic        pcout;
    logic        pcin;
    logic        incpc;
    logic        marin;
    logic        irin;
    logic        mdrout;
    logic        mdrin;
    logic        mdrread;
    logic        yin;
    logic        zin;
    logic        zhighout;
    logic        zlowout;
    logic        hiin;
    logic        loin;
    logic [11:0] alu;
    logic        illegal;
  } strobes_t;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or,
      c_op_shr, c_op_shl, c_op_ror, c_op_rol,
      c_op_mul, c_op_div:   cls = CLS_ALU3;
      c_op_not, c_op_neg:   cls = CLS_UNARY;
      c_op_nop:             cls = CLS_NOP;
      c_op_halt:            cls = CLS_HALT;
      default:              cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [11:0] alu_select(input logic [4:0] op);
    logic [11:0] sel;
    sel = '0;
    case (op)
      c_op_add: sel[c_alu_add] = 1'b1;
      c_op_sub: sel[c_alu_sub] = 1'b1;
      c_op_and: sel[c_alu_and] = 1'b1;
      c_op_or:  sel[c_alu_or]  = 1'b1;
      c_op_shr: sel[c_alu_shr] = 1'b1;
      c_op_shl: sel[c_alu_shl] = 1'b1;
      c_op_ror: sel[c_alu_ror] = 1'b1;
      c_op_rol: sel[c_alu_rol] = 1'b1;
      c_op_mul: sel[c_alu_mul] = 1'b1;
      c_op_div: sel[c_alu_div] = 1'b1;
      c_op_neg: sel[c_alu_neg] = 1'b1;
      c_op_not: sel[c_alu_not] = 1'b1;
      default:  sel = '0;
    endcase
    return sel;
  endfunction

  // MUL/DIV produce a 64-bit result that lands in HI/LO instead of Ra
  function automatic logic is_wide_result(input logic [4:0] op);
    return (op == c_op_mul) || (op == c_op_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_sel_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : reg_sel_decoder
//  Purpose  : 4-bit register index plus enable to a 16-bit one-hot select.
//             Output is all-zero when the enable is low.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_sel_decoder (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] sel_o
);

  // One comparator per register line keeps the result one-hot by construction
  for (genvar i = 0; i < 16; i++) begin : g_sel
    assign sel_o[i] = en_i && (idx_i == 4'(i));
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_sequencer
//  Purpose  : Hardwired control unit for the phase-1 bus datapath. Sequences
//             fetch (T0-T2) and execute (T3-T6) and drives the register,
//             memory and ALU strobes as a decode of state plus IR fields.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
  parameter int unsigned RESET_PC_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run_en,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        IRin,
  output logic        MDRout,
  output logic        MDRin,
  output logic        MDRRead,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic [11:0] ALUControl,
  output logic        run,
  output logic        illegal_op
);
  import ctrl_pkg::*;

  // Counter only ever reaches RESET_PC_WAIT-1 before saturating
  localparam int unsigned c_wait_w = (RESET_PC_WAIT < 2) ? 1 : $clog2(RESET_PC_WAIT);

  state_e                state_q, state_d;
  logic [c_wait_w-1:0]   wait_q, wait_d;
  logic                  t1_wait_q;
  logic [16:0]           ir_q;

  logic [16:0]           w_ir_hi;
  logic [4:0]            w_op;
  logic [3:0]            w_ra, w_rb, w_rc;
  op_class_e             w_class;
  logic                  w_wide;
  logic [11:0]           w_alu;
  logic                  w_wait_done;

  strobes_t              w_sb, w_sb_out;
  logic                  w_rout_en, w_rin_en;
  logic [3:0]            w_rout_idx, w_rin_idx;

  // Low IR bits carry immediates that this control unit never looks at
  logic                  w_unused_ir;
  assign w_unused_ir = ^ir[14:0];

  // The datapath IR loads at the edge ending T2, so T3 decodes it live and
  // snapshots it; T4-T6 then work from the snapshot.
  assign w_ir_hi = (state_q == ST_T3) ? ir[31:15] : ir_q;
  assign w_op    = w_ir_hi[16:12];
  assign w_ra    = w_ir_hi[11:8];
  assign w_rb    = w_ir_hi[7:4];
  assign w_rc    = w_ir_hi[3:0];

  assign w_class = op_class(w_op);
  assign w_wide  = is_wide_result(w_op);
  assign w_alu   = alu_select(w_op);

  // IDLE always lasts at least one cycle because reset itself lands there
  assign w_wait_done = (32'(wait_q) + 32'd1) >= 32'(RESET_PC_WAIT);

  // State, wait counter, T1 re-entry flag and IR snapshot
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      t1_wait_q <= 1'b0;
      ir_q      <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      t1_wait_q <= (state_q == ST_T1) && !mem_ready;
      if (state_q == ST_T3) begin
        ir_q <= ir[31:15];
      end
    end
  end

  // Next-state and Moore strobe decode
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    w_sb       = '0;
    w_rout_en  = 1'b0;
    w_rout_idx = '0;
    w_rin_en   = 1'b0;
    w_rin_idx  = '0;

    case (state_q)
      ST_IDLE: begin
        if (!w_wait_done) begin
          wait_d = wait_q + c_wait_w'(1);
        end else if (run_en) begin
          state_d = ST_T0;
        end
      end

      ST_T0: begin
        if (run_en) begin
          w_sb.pcout = 1'b1;
          w_sb.marin = 1'b1;
          w_sb.incpc = 1'b1;
          w_sb.zin   = 1'b1;
          state_d    = ST_T1;
        end
      end

      ST_T1: begin
        // PC is written back only once even if memory stalls
        w_sb.mdrread = 1'b1;
        w_sb.mdrin   = 1'b1;
        if (!t1_wait_q) begin
          w_sb.zlowout = 1'b1;
          w_sb.pcin    = 1'b1;
        end
        if (mem_ready) begin
          state_d = ST_T2;
        end
      end

      ST_T2: begin
        w_sb.mdrout = 1'b1;
        w_sb.irin   = 1'b1;
        state_d     = ST_T3;
      end

      ST_T3: begin
        case (w_class)
          CLS_ALU3: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_rb;
            w_sb.yin   = 1'b1;
            state_d    = ST_T4;
          end
          CLS_UNARY: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_rb;
            w_sb.alu   = w_alu;
            w_sb.zin   = 1'b1;
            state_d    = ST_T4;
          end
          CLS_NOP:  state_d = ST_T0;
          CLS_HALT: state_d = ST_HALTED;
          default: begin
            w_sb.illegal = 1'b1;
            state_d      = ST_T0;
          end
        endcase
      end

      ST_T4: begin
        if (w_class == CLS_UNARY) begin
          w_sb.zlowout = 1'b1;
          w_rin_en     = 1'b1;
          w_rin_idx    = w_ra;
          state_d      = ST_T0;
        end else begin
          w_rout_en  = 1'b1;
          w_rout_idx = w_rc;
          w_sb.alu   = w_alu;
          w_sb.zin   = 1'b1;
          state_d    = ST_T5;
        end
      end

      ST_T5: begin
        w_sb.zlowout = 1'b1;
        if (w_wide) begin
          w_sb.loin = 1'b1;
          state_d   = ST_T6;
        end else begin
          w_rin_en  = 1'b1;
          w_rin_idx = w_ra;
          state_d   = ST_T0;
        end
      end

      ST_T6: begin
        w_sb.zhighout = 1'b1;
        w_sb.hiin     = 1'b1;
        state_d       = ST_T0;
      end

      ST_HALTED: state_d = ST_HALTED;

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset blanks every output in the same cycle so an aborted step leaves no strobe
  assign w_sb_out = clr ? '0 : w_sb;

  reg_sel_decoder u_rout_dec (
    .idx_i (w_rout_idx),
    .en_i  (w_rout_en && !clr),
    .sel_o (Rout)
  );

  reg_sel_decoder u_rin_dec (
    .idx_i (w_rin_idx),
    .en_i  (w_rin_en && !clr),
    .sel_o (Rin)
  );

  assign PCout      = w_sb_out.pcout;
  assign PCin       = w_sb_out.pcin;
  assign IncPC      = w_sb_out.incpc;
  assign MARin      = w_sb_out.marin;
  assign IRin       = w_sb_out.irin;
  assign MDRout     = w_sb_out.mdrout;
  assign MDRin      = w_sb_out.mdrin;
  assign MDRRead    = w_sb_out.mdrread;
  assign Yin        = w_sb_out.yin;
  assign Zin        = w_sb_out.zin;
  assign Zhighout   = w_sb_out.zhighout;
  assign Zlowout    = w_sb_out.zlowout;
  assign HIin       = w_sb_out.hiin;
  assign LOin       = w_sb_out.loin;
  assign ALUControl = w_sb_out.alu;
  assign illegal_op = w_sb_out.illegal;
  assign run        = !clr && (state_q != ST_IDLE) && (state_q != ST_HALTED);

endmodule
`default_nettype wire
